// File: rtl/weight_result_collector.sv
// Tail-of-chain collector: captures flagged results into a FWFT FIFO with cell id tags.
// Optional COLLECTOR_CLAMP_EN: payload = min(raw >> SHIFT, 2**OUT_WIDTH-1) at push.
module weight_result_collector #(
  parameter int RESULT_WIDTH = 16,
  parameter int CELL_COUNT   = 4,
  parameter int ID_WIDTH     = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int SHIFT        = 0,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RESULT_WIDTH:0]         in_result,
  output logic [RESULT_WIDTH-1:0]       out_data,
  output logic [ID_WIDTH-1:0]           out_cell_id,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ID_WIDTH + 1 + RESULT_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(CELL_COUNT - 1);

  logic [EW-1:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr;
  logic [PW-1:0]           r_rd;
  logic [CW-1:0]           r_count;
  logic [ID_WIDTH-1:0]     r_id;
  logic                    r_ovf;

  logic                    w_flag;
  logic [RESULT_WIDTH-1:0] w_raw;
  logic [RESULT_WIDTH-1:0] w_payload;
  logic                    w_last_in;
  logic                    w_pop;
  logic                    w_push;
  logic [EW-1:0]           w_entry;
  logic [EW-1:0]           w_head;

  assign w_flag = in_result[RESULT_WIDTH];
  assign w_raw  = in_result[RESULT_WIDTH-1:0];

`ifdef COLLECTOR_CLAMP_EN
  localparam logic [RESULT_WIDTH-1:0] CEIL =
    RESULT_WIDTH'((64'd1 << OUT_WIDTH) - 64'd1);
  logic [RESULT_WIDTH-1:0] w_shifted;
  assign w_shifted = w_raw >> SHIFT;
  assign w_payload = (w_shifted > CEIL) ? CEIL : w_shifted;
`else
  logic w_unused_clamp;
  assign w_unused_clamp = |{32'(SHIFT), 32'(OUT_WIDTH)};
  assign w_payload = w_raw;
`endif

  assign w_last_in = (r_id == LAST_ID);
  assign w_entry   = {r_id, w_last_in, w_payload};

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign w_push    = w_flag & ((r_count != FULL) | w_pop);

  assign w_head      = r_mem[r_rd];
  assign out_data    = out_valid ? w_head[RESULT_WIDTH-1:0] : '0;
  assign out_last    = out_valid ? w_head[RESULT_WIDTH] : 1'b0;
  assign out_cell_id = out_valid ? w_head[EW-1 -: ID_WIDTH] : '0;
  assign fifo_count  = r_count;
  assign overflow    = r_ovf;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_id    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Id advances on dropped words too, keeping vector alignment.
      if (w_flag) r_id <= w_last_in ? '0 : r_id + 1'b1;
      if (w_flag & ~w_push) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_result_collector.sv
// Scoreboard bench for weight_result_collector.
// Driver queues expected outputs; a negedge monitor pops and compares on handshake.
module tb_weight_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] in_result;
  logic [15:0] out_data;
  logic [3:0]  out_cell_id;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_count;
  logic        overflow;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  id;
    logic        last;
  } exp_t;

  exp_t     q[$];
  int       total = 0;
  int       bad = 0;
  int       m_id = 0;

  always #5 clk = ~clk;

  weight_result_collector #(
    .RESULT_WIDTH(16), .CELL_COUNT(4), .ID_WIDTH(4),
    .FIFO_DEPTH(8), .SHIFT(4), .OUT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .in_result(in_result),
    .out_data(out_data), .out_cell_id(out_cell_id),
    .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {16'h0, out_data}, 32'hdead);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", {16'h0, out_data}, {16'h0, e.data});
        chk("out_cell_id", {28'h0, out_cell_id}, {28'h0, e.id});
        chk("out_last", {31'h0, out_last}, {31'h0, e.last});
      end
    end else if (!out_valid) begin
      chk("idle_zero", {11'h0, out_data, out_cell_id, out_last}, 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit flag, input logic [15:0] p,
                      input logic [15:0] expd, input bit keep);
    exp_t e;
    in_result = {flag, p};
    if (flag) begin
      if (keep) begin
        e.data = expd;
        e.id   = 4'(m_id);
        e.last = (m_id == 3);
        q.push_back(e);
      end
      m_id = (m_id + 1) % 4;
    end
    cyc();
    in_result = '0;
  endtask

  task automatic do_reset();
    out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    q.delete();
    m_id = 0;
  endtask

  task automatic drain(input string n);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) cyc();
    cyc();
    chk({n, "_drained"}, q.size(), 0);
    chk({n, "_count0"}, {28'h0, fifo_count}, 32'h0);
  endtask

  initial begin
    in_result = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_valid", {31'h0, out_valid}, 0);
    chk("rst_count", {28'h0, fifo_count}, 0);
    chk("rst_ovf", {31'h0, overflow}, 0);
    chk("rst_data", {16'h0, out_data}, 0);

    // 1: back-to-back with ready, FWFT latency
    out_ready = 1'b1;
    send(1'b1, 16'h0001, 16'h0001, 1'b1);
    chk("t1_fwft_valid", {31'h0, out_valid}, 1);
    chk("t1_fwft_data", {16'h0, out_data}, 1);
    send(1'b1, 16'h0002, 16'h0002, 1'b1);
    chk("t1_count_steady", {28'h0, fifo_count}, 1);
    send(1'b1, 16'h0003, 16'h0003, 1'b1);
    send(1'b1, 16'h0004, 16'h0004, 1'b1);
    drain("t1");

    // 2: overflow with stalled consumer
    do_reset();
    for (int i = 0; i < 9; i++)
      send(1'b1, 16'(16'h0100 + i), 16'(16'h0100 + i), i < 8);
    chk("t2_count_full", {28'h0, fifo_count}, 8);
    chk("t2_ovf", {31'h0, overflow}, 1);
    chk("t2_hold_data", {16'h0, out_data}, 32'h0100);
    drain("t2");
    chk("t2_ovf_sticky", {31'h0, overflow}, 1);

    // 3: full, simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++)
      send(1'b1, 16'(16'h0200 + i), 16'(16'h0200 + i), 1'b1);
    chk("t3_full", {28'h0, fifo_count}, 8);
    out_ready = 1'b1;
    send(1'b1, 16'h00AA, 16'h00AA, 1'b1);
    chk("t3_count_stays", {28'h0, fifo_count}, 8);
    chk("t3_no_ovf", {31'h0, overflow}, 0);
    drain("t3");

    // 4: unflagged words ignored
    do_reset();
    out_ready = 1'b1;
    send(1'b1, 16'h0011, 16'h0011, 1'b1);
    send(1'b0, 16'hFFFF, 16'h0000, 1'b0);
    send(1'b1, 16'h0022, 16'h0022, 1'b1);
    send(1'b0, 16'hFFFF, 16'h0000, 1'b0);
    send(1'b1, 16'h0033, 16'h0033, 1'b1);
    send(1'b1, 16'h0044, 16'h0044, 1'b1);
    send(1'b1, 16'h0055, 16'h0055, 1'b1);
    drain("t4");

    // 5: reset mid-stream
    do_reset();
    send(1'b1, 16'h0301, 16'h0301, 1'b1);
    send(1'b1, 16'h0302, 16'h0302, 1'b1);
    send(1'b1, 16'h0303, 16'h0303, 1'b1);
    chk("t5_count3", {28'h0, fifo_count}, 3);
    do_reset();
    chk("t5_valid", {31'h0, out_valid}, 0);
    chk("t5_count", {28'h0, fifo_count}, 0);
    chk("t5_ovf", {31'h0, overflow}, 0);
    send(1'b1, 16'h0399, 16'h0399, 1'b1);
    chk("t5_id0", {28'h0, out_cell_id}, 0);
    drain("t5");

    // 6: clamp path
    do_reset();
    out_ready = 1'b1;
`ifdef COLLECTOR_CLAMP_EN
    send(1'b1, 16'h0FF0, 16'h00FF, 1'b1);
    send(1'b1, 16'h0120, 16'h0012, 1'b1);
`else
    send(1'b1, 16'h0FF0, 16'h0FF0, 1'b1);
    send(1'b1, 16'h0120, 16'h0120, 1'b1);
`endif
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
